// File: rtl/ptp_pkg.sv
// Shared PTP time-of-day definitions: 96-bit timestamp layout and ns-per-second constant.
package ptp_pkg;

    localparam int unsigned TS_W     = 96;
    localparam int unsigned S_W      = 48;
    localparam int unsigned NS_W     = 30;
    localparam int unsigned FNS_W    = 16;
    localparam int unsigned INC_NS_W = 4;
    localparam int unsigned ADJ_CNT_W = 16;

    localparam int unsigned TS_S_MSB   = 95;
    localparam int unsigned TS_S_LSB   = 48;
    localparam int unsigned TS_NS_MSB  = 45;
    localparam int unsigned TS_NS_LSB  = 16;
    localparam int unsigned TS_FNS_MSB = 15;
    localparam int unsigned TS_FNS_LSB = 0;

    localparam logic [NS_W-1:0] NS_PER_S = 30'd1_000_000_000;

    // Bits [47:46] are reserved and always read as zero on the output.
    typedef struct packed {
        logic [S_W-1:0]   s;
        logic [1:0]       rsvd;
        logic [NS_W-1:0]  ns;
        logic [FNS_W-1:0] fns;
    } ts96_t;

    function automatic logic [TS_W-1:0] ts_pack(input logic [S_W-1:0] s,
                                                input logic [NS_W-1:0] ns,
                                                input logic [FNS_W-1:0] fns);
        return {s, 2'b00, ns, fns};
    endfunction

endpackage

// File: rtl/ptp_tod_clock_if.sv
// Control and timestamp bus of the ToD clock; master is the controller, slave the clock.
interface ptp_tod_clock_if;
    import ptp_pkg::*;

    logic [TS_W-1:0]      input_ts_96;
    logic                 input_ts_96_valid;
    logic [INC_NS_W-1:0]  input_period_ns;
    logic [FNS_W-1:0]     input_period_fns;
    logic                 input_period_valid;
    logic [INC_NS_W-1:0]  input_adj_ns;
    logic [FNS_W-1:0]     input_adj_fns;
    logic [ADJ_CNT_W-1:0] input_adj_count;
    logic                 input_adj_valid;
    logic                 input_adj_active;
    logic [TS_W-1:0]      output_ts_96;
    logic                 output_ts_step;
    logic                 output_pps;

    modport master (
        output input_ts_96, input_ts_96_valid,
        output input_period_ns, input_period_fns, input_period_valid,
        output input_adj_ns, input_adj_fns, input_adj_count, input_adj_valid,
        input  input_adj_active, output_ts_96, output_ts_step, output_pps
    );

    modport slave (
        input  input_ts_96, input_ts_96_valid,
        input  input_period_ns, input_period_fns, input_period_valid,
        input  input_adj_ns, input_adj_fns, input_adj_count, input_adj_valid,
        output input_adj_active, output_ts_96, output_ts_step, output_pps
    );

endinterface

// File: rtl/ptp_ts_ns_add.sv
// Adds the per-cycle increment to {ns,fns}, resolving second rollover via a parallel subtract.
module ptp_ts_ns_add
    import ptp_pkg::*;
(
    input  logic [NS_W-1:0]     ns,
    input  logic [FNS_W-1:0]    fns,
    input  logic [INC_NS_W-1:0] inc_ns,
    input  logic [FNS_W-1:0]    inc_fns,
    output logic [NS_W-1:0]     sum_ns_c,
    output logic [FNS_W-1:0]    sum_fns_c,
    output logic                rollover_c
);

    localparam int unsigned SUM_W = NS_W + FNS_W;

    logic [SUM_W-1:0] sum;
    logic [SUM_W:0]   diff;

    // ns < 1e9 and inc_ns < 16 keep the sum inside 30 ns bits; diff MSB is the borrow.
    always_comb begin
        sum        = {ns, fns} + {(NS_W - INC_NS_W)'(0), inc_ns, inc_fns};
        diff       = {1'b0, sum} - {1'b0, NS_PER_S, FNS_W'(0)};
        rollover_c = ~diff[SUM_W];
        if (rollover_c) begin
            sum_ns_c  = diff[SUM_W-1:FNS_W];
            sum_fns_c = diff[FNS_W-1:0];
        end else begin
            sum_ns_c  = sum[SUM_W-1:FNS_W];
            sum_fns_c = sum[FNS_W-1:0];
        end
    end

endmodule

// File: rtl/ptp_tod_clock.sv
// PTP time-of-day counter with load, programmable period and timed frequency adjustment.
module ptp_tod_clock
    import ptp_pkg::*;
#(
    parameter bit                  FNS_ENABLE = 1'b1,
    parameter logic [INC_NS_W-1:0] PERIOD_NS  = 4'h6,
    parameter logic [FNS_W-1:0]    PERIOD_FNS = 16'h6666
) (
    input  logic               clk,
    input  logic               rst,
    ptp_tod_clock_if.slave     tod
);

    logic [S_W-1:0]       s_reg, s_nxt;
    logic [NS_W-1:0]      ns_reg, ns_nxt;
    logic [FNS_W-1:0]     fns_reg, fns_nxt;
    logic                 step_reg, step_nxt;
    logic                 pps_reg, pps_nxt;
    logic [INC_NS_W-1:0]  period_ns_reg, period_ns_nxt;
    logic [FNS_W-1:0]     period_fns_reg, period_fns_nxt;
    logic [INC_NS_W-1:0]  adj_ns_reg, adj_ns_nxt;
    logic [FNS_W-1:0]     adj_fns_reg, adj_fns_nxt;
    logic [ADJ_CNT_W-1:0] adj_cnt_reg, adj_cnt_nxt;
    logic                 adj_active_reg, adj_active_nxt;

    ts96_t                ld;
    logic                 load_ok;
    logic                 adj_on;
    logic [INC_NS_W-1:0]  inc_ns;
    logic [FNS_W-1:0]     inc_fns;
    logic [NS_W-1:0]      add_ns;
    logic [FNS_W-1:0]     add_fns;
    logic                 add_roll;

    assign ld      = ts96_t'(tod.input_ts_96);
    assign load_ok = tod.input_ts_96_valid && (ld.ns < NS_PER_S);
    assign adj_on  = (adj_cnt_reg != ADJ_CNT_W'(0));
    assign inc_ns  = adj_on ? adj_ns_reg : period_ns_reg;
    assign inc_fns = FNS_ENABLE ? (adj_on ? adj_fns_reg : period_fns_reg) : FNS_W'(0);

    ptp_ts_ns_add u_ns_add (
        .ns         (ns_reg),
        .fns        (fns_reg),
        .inc_ns     (inc_ns),
        .inc_fns    (inc_fns),
        .sum_ns_c   (add_ns),
        .sum_fns_c  (add_fns),
        .rollover_c (add_roll)
    );

    // Next-state: a valid load wins over counting and cancels any adjustment.
    always_comb begin
        s_nxt          = s_reg;
        ns_nxt         = ns_reg;
        fns_nxt        = fns_reg;
        step_nxt       = 1'b0;
        pps_nxt        = 1'b0;
        period_ns_nxt  = period_ns_reg;
        period_fns_nxt = period_fns_reg;
        adj_ns_nxt     = adj_ns_reg;
        adj_fns_nxt    = adj_fns_reg;
        adj_cnt_nxt    = adj_cnt_reg;

        if (tod.input_period_valid) begin
            period_ns_nxt  = tod.input_period_ns;
            period_fns_nxt = tod.input_period_fns;
        end

        if (load_ok) begin
            s_nxt       = ld.s;
            ns_nxt      = ld.ns;
            fns_nxt     = FNS_ENABLE ? ld.fns : FNS_W'(0);
            step_nxt    = 1'b1;
            adj_cnt_nxt = ADJ_CNT_W'(0);
        end else begin
            ns_nxt  = add_ns;
            fns_nxt = add_fns;
            if (add_roll) begin
                s_nxt   = s_reg + S_W'(1);
                pps_nxt = 1'b1;
            end
            if (adj_on) begin
                adj_cnt_nxt = adj_cnt_reg - ADJ_CNT_W'(1);
            end else if (tod.input_adj_valid) begin
                adj_ns_nxt  = tod.input_adj_ns;
                adj_fns_nxt = tod.input_adj_fns;
                adj_cnt_nxt = tod.input_adj_count;
            end
        end

        adj_active_nxt = (adj_cnt_nxt != ADJ_CNT_W'(0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg          <= '0;
            ns_reg         <= '0;
            fns_reg        <= '0;
            step_reg       <= 1'b0;
            pps_reg        <= 1'b0;
            period_ns_reg  <= PERIOD_NS;
            period_fns_reg <= PERIOD_FNS;
            adj_ns_reg     <= '0;
            adj_fns_reg    <= '0;
            adj_cnt_reg    <= '0;
            adj_active_reg <= 1'b0;
        end else begin
            s_reg          <= s_nxt;
            ns_reg         <= ns_nxt;
            fns_reg        <= fns_nxt;
            step_reg       <= step_nxt;
            pps_reg        <= pps_nxt;
            period_ns_reg  <= period_ns_nxt;
            period_fns_reg <= period_fns_nxt;
            adj_ns_reg     <= adj_ns_nxt;
            adj_fns_reg    <= adj_fns_nxt;
            adj_cnt_reg    <= adj_cnt_nxt;
            adj_active_reg <= adj_active_nxt;
        end
    end

    assign tod.output_ts_96     = ts_pack(s_reg, ns_reg, fns_reg);
    assign tod.output_ts_step   = step_reg;
    assign tod.output_pps       = pps_reg;
    assign tod.input_adj_active = adj_active_reg;

endmodule

// File: tb/tb_ptp_tod_clock.sv
// Directed bench for ptp_tod_clock with hand-computed expected timestamps.
module tb_ptp_tod_clock;
    import ptp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    ptp_tod_clock_if tod ();

    ptp_tod_clock #(
        .FNS_ENABLE (1'b1),
        .PERIOD_NS  (4'h6),
        .PERIOD_FNS (16'h6666)
    ) dut (
        .clk (clk),
        .rst (rst),
        .tod (tod.slave)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] ts(input logic [47:0] s, input logic [29:0] ns,
                                       input logic [15:0] fns);
        return {s, 2'b00, ns, fns};
    endfunction

    task automatic check_flags(input string tag, input logic step, input logic pps,
                               input logic active);
        check({tag, "_step"}, 96'(tod.output_ts_step), 96'(step));
        check({tag, "_pps"}, 96'(tod.output_pps), 96'(pps));
        check({tag, "_active"}, 96'(tod.input_adj_active), 96'(active));
    endtask

    initial begin
        rst                    = 1'b1;
        tod.input_ts_96        = '0;
        tod.input_ts_96_valid  = 1'b0;
        tod.input_period_ns    = '0;
        tod.input_period_fns   = '0;
        tod.input_period_valid = 1'b0;
        tod.input_adj_ns       = '0;
        tod.input_adj_fns      = '0;
        tod.input_adj_count    = '0;
        tod.input_adj_valid    = 1'b0;

        // Reset state
        tick(3);
        check("rst_ts", tod.output_ts_96, ts(48'd0, 30'd0, 16'h0));
        check_flags("rst", 1'b0, 1'b0, 1'b0);

        // Free run at 6.6666h: 0x6666*5 = 0x1FFFE -> ns 31, fns FFFE
        rst = 1'b0;
        tick(5);
        check("run5_ts", tod.output_ts_96, ts(48'd0, 30'd31, 16'hFFFE));

        // Period 8.0, then load just below a second boundary
        tod.input_period_ns    = 4'd8;
        tod.input_period_fns   = 16'h0;
        tod.input_period_valid = 1'b1;
        tick(1);
        tod.input_period_valid = 1'b0;
        tod.input_ts_96        = ts(48'd5, 30'd999_999_990, 16'h0);
        tod.input_ts_96_valid  = 1'b1;
        tick(1);
        tod.input_ts_96_valid  = 1'b0;
        check("load_ts", tod.output_ts_96, ts(48'd5, 30'd999_999_990, 16'h0));
        check_flags("load", 1'b1, 1'b0, 1'b0);
        tick(1);
        check("pre_roll_ts", tod.output_ts_96, ts(48'd5, 30'd999_999_998, 16'h0));
        check_flags("pre_roll", 1'b0, 1'b0, 1'b0);
        tick(1);
        check("roll_ts", tod.output_ts_96, ts(48'd6, 30'd6, 16'h0));
        check_flags("roll", 1'b0, 1'b1, 1'b0);
        tick(1);
        check("post_roll_ts", tod.output_ts_96, ts(48'd6, 30'd14, 16'h0));
        check_flags("post_roll", 1'b0, 1'b0, 1'b0);

        // Out-of-range ns load is ignored
        tod.input_ts_96       = ts(48'd9, 30'd1_000_000_000, 16'h0);
        tod.input_ts_96_valid = 1'b1;
        tick(1);
        tod.input_ts_96_valid = 1'b0;
        check("bad_load_ts", tod.output_ts_96, ts(48'd6, 30'd22, 16'h0));
        check_flags("bad_load", 1'b0, 1'b0, 1'b0);

        // Adjustment 9.0 x3; a second request while active is dropped
        tod.input_adj_ns    = 4'd9;
        tod.input_adj_fns   = 16'h0;
        tod.input_adj_count = 16'd3;
        tod.input_adj_valid = 1'b1;
        tick(1);
        check("adj_acc_ts", tod.output_ts_96, ts(48'd6, 30'd30, 16'h0));
        check_flags("adj_acc", 1'b0, 1'b0, 1'b1);
        tod.input_adj_ns    = 4'd1;
        tod.input_adj_count = 16'd5;
        tick(1);
        tod.input_adj_valid = 1'b0;
        check("adj1_ts", tod.output_ts_96, ts(48'd6, 30'd39, 16'h0));
        check_flags("adj1", 1'b0, 1'b0, 1'b1);
        tick(1);
        check("adj2_ts", tod.output_ts_96, ts(48'd6, 30'd48, 16'h0));
        check_flags("adj2", 1'b0, 1'b0, 1'b1);
        tick(1);
        check("adj3_ts", tod.output_ts_96, ts(48'd6, 30'd57, 16'h0));
        check_flags("adj3", 1'b0, 1'b0, 1'b0);
        tick(1);
        check("adj_done_ts", tod.output_ts_96, ts(48'd6, 30'd65, 16'h0));
        tick(1);
        check("adj_idle_ts", tod.output_ts_96, ts(48'd6, 30'd73, 16'h0));
        check_flags("adj_idle", 1'b0, 1'b0, 1'b0);

        // Load cancels an active adjustment
        tod.input_adj_ns    = 4'd9;
        tod.input_adj_count = 16'd10;
        tod.input_adj_valid = 1'b1;
        tick(1);
        check("adj_b_ts", tod.output_ts_96, ts(48'd6, 30'd81, 16'h0));
        check_flags("adj_b", 1'b0, 1'b0, 1'b1);
        tod.input_ts_96       = ts(48'd7, 30'd100, 16'h0);
        tod.input_ts_96_valid = 1'b1;
        tick(1);
        tod.input_ts_96_valid = 1'b0;
        tod.input_adj_valid   = 1'b0;
        check("cancel_ts", tod.output_ts_96, ts(48'd7, 30'd100, 16'h0));
        check_flags("cancel", 1'b1, 1'b0, 1'b0);
        tick(1);
        check("cancel_next_ts", tod.output_ts_96, ts(48'd7, 30'd108, 16'h0));
        check_flags("cancel_next", 1'b0, 1'b0, 1'b0);

        // Load with an idle adjuster and same-cycle adj request: request dropped
        tod.input_ts_96       = ts(48'd7, 30'd200, 16'h0);
        tod.input_ts_96_valid = 1'b1;
        tod.input_adj_count   = 16'd4;
        tod.input_adj_valid   = 1'b1;
        tick(1);
        tod.input_ts_96_valid = 1'b0;
        tod.input_adj_valid   = 1'b0;
        check("ld_adj_ts", tod.output_ts_96, ts(48'd7, 30'd200, 16'h0));
        check_flags("ld_adj", 1'b1, 1'b0, 1'b0);
        tick(1);
        check("ld_adj_next_ts", tod.output_ts_96, ts(48'd7, 30'd208, 16'h0));
        check_flags("ld_adj_next", 1'b0, 1'b0, 1'b0);

        // Reset mid-adjustment with every request asserted
        tod.input_adj_count = 16'd10;
        tod.input_adj_valid = 1'b1;
        tick(1);
        check("pre_rst_ts", tod.output_ts_96, ts(48'd7, 30'd216, 16'h0));
        check_flags("pre_rst", 1'b0, 1'b0, 1'b1);
        rst                    = 1'b1;
        tod.input_ts_96        = ts(48'd3, 30'd500, 16'h0);
        tod.input_ts_96_valid  = 1'b1;
        tod.input_period_ns    = 4'd5;
        tod.input_period_valid = 1'b1;
        tick(1);
        rst                    = 1'b0;
        tod.input_ts_96_valid  = 1'b0;
        tod.input_period_valid = 1'b0;
        tod.input_adj_valid    = 1'b0;
        check("mid_rst_ts", tod.output_ts_96, ts(48'd0, 30'd0, 16'h0));
        check_flags("mid_rst", 1'b0, 1'b0, 1'b0);
        tick(1);
        check("rst_period1_ts", tod.output_ts_96, ts(48'd0, 30'd6, 16'h6666));
        check_flags("rst_period1", 1'b0, 1'b0, 1'b0);
        tick(1);
        check("rst_period2_ts", tod.output_ts_96, ts(48'd0, 30'd12, 16'hCCCC));

        // Seconds wrap at 2^48; reserved bits [47:46] of the load value are dropped
        tod.input_ts_96       = {48'hFFFF_FFFF_FFFF, 2'b11, 30'd999_999_995, 16'h0};
        tod.input_ts_96_valid = 1'b1;
        tick(1);
        tod.input_ts_96_valid = 1'b0;
        check("wrap_load_ts", tod.output_ts_96, ts(48'hFFFF_FFFF_FFFF, 30'd999_999_995, 16'h0));
        check_flags("wrap_load", 1'b1, 1'b0, 1'b0);
        tick(1);
        check("wrap_ts", tod.output_ts_96, ts(48'd0, 30'd1, 16'h6666));
        check_flags("wrap", 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
